mem_sram_ctrl: RTL

Memory-side responder for the MEM stage's load/store request interface: accepts `ramOp`/`ramAddr`/`storeData`, runs a multi-cycle access on an asynchronous 32-bit SRAM, and returns `success` with extended load data. It sits between the MEM stage and the board SRAM pins. The MEM stage holds its request stable and stalls the pipeline until `success_o` is seen.

---
 rtl/mem_defs.sv | 45 ++++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_sram_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_defs.sv
// mem_defs: shared definitions for the MEM-stage SRAM responder.
//   - mem_op_e     : 4-bit load/store operation encoding driven by the MEM stage
//   - state_e      : controller state encoding (IDLE, ACCESS, DONE)
//   - is_load / is_store / is_req : op classification helpers
//   - is_misaligned: alignment rule used when MEM_ALIGN_CHECK_EN is defined
package mem_defs;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Undefined codes (9..15) classify as neither, so they behave like MEM_NOP.
    function automatic logic is_req(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        return (((op == MEM_LW) || (op == MEM_SW)) && (addr_lo != 2'b00)) ||
               (((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane steering for the SRAM responder.
//   op, addr_lo   : operation and byte offset within the 32-bit word
//   store_data    : right-aligned store data
//   rdata         : raw SRAM word
//   wdata         : store data replicated onto the byte lanes
//   be_n          : active-low byte enables (0000 for loads, 1111 for no op)
//   load_data     : sign/zero-extended load result (0 for stores and no op)
module mem_lane_align
    import mem_defs::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be_n,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        // addr_lo[0] is deliberately ignored for halfwords.
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wdata     = '0;
        be_n      = 4'b1111;
        load_data = '0;
        case (op)
            MEM_LB:  begin be_n = 4'b0000; load_data = {{24{rd_byte[7]}}, rd_byte}; end
            MEM_LBU: begin be_n = 4'b0000; load_data = {24'd0, rd_byte}; end
            MEM_LH:  begin be_n = 4'b0000; load_data = {{16{rd_half[15]}}, rd_half}; end
            MEM_LHU: begin be_n = 4'b0000; load_data = {16'd0, rd_half}; end
            MEM_LW:  begin be_n = 4'b0000; load_data = rdata; end
            // Stores replicate the data so whichever lane is enabled sees it.
            MEM_SB:  begin wdata = {4{store_data[7:0]}};  be_n = ~(4'b0001 << addr_lo); end
            MEM_SH:  begin wdata = {2{store_data[15:0]}}; be_n = addr_lo[1] ? 4'b0011 : 4'b1100; end
            MEM_SW:  begin wdata = store_data;            be_n = 4'b0000; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage load/store responder driving an asynchronous
// 32-bit SRAM. A request is taken in IDLE, the strobes are held for
// WAIT_CYCLES cycles in ACCESS, and DONE gives a one-cycle success pulse.
// All outputs are registered.
//   clk, rst           : clock, synchronous active-high reset
//   ramOp_i/ramAddr_i/storeData_i : request from the MEM stage
//   success_o, loadData_o, misalign_o : completion pulse, extended load data,
//                        misalignment pulse
//   sram_*             : SRAM address, data, drive enable and active-low strobes
//   state_dbg          : current controller state (mem_defs::state_e)
// Optional build macro: MEM_ALIGN_CHECK_EN -- misaligned word/halfword requests
// skip the SRAM and complete after one cycle with misalign_o set.
module mem_sram_ctrl
    import mem_defs::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ramOp_i,
    input  logic [31:0]       ramAddr_i,
    input  logic [31:0]       storeData_i,
    output logic              success_o,
    output logic [31:0]       loadData_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic [1:0]        state_dbg
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e            state, state_n;
    logic [CW-1:0]     wait_cnt, wait_cnt_n;
    logic [3:0]        op_q, op_n;
    logic [1:0]        addr_lo_q, addr_lo_n;
    logic [ADDR_W-1:0] addr_n;
    logic              mis_q, mis_n, mis_req;
    logic              accept, capture, in_access, active;
    logic [31:0]       lane_wdata, lane_load;
    logic [3:0]        lane_be_n;

    // Byte-address bits above the SRAM word address are not used.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, ramAddr_i[31:ADDR_W+2]};

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_req = is_misaligned(ramOp_i, ramAddr_i[1:0]);
`else
    assign mis_req = 1'b0;
`endif

    assign accept  = (state == IDLE) && is_req(ramOp_i);
    assign capture = (state == ACCESS) && (wait_cnt == '0);

    // Steering works on the op/offset that will be current next cycle, so the
    // registered be_n/dq outputs line up with the first ACCESS cycle.
    mem_lane_align u_lane_align (
        .op         (op_n),
        .addr_lo    (addr_lo_n),
        .store_data (storeData_i),
        .rdata      (sram_dq_i),
        .wdata      (lane_wdata),
        .be_n       (lane_be_n),
        .load_data  (lane_load)
    );

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        op_n       = op_q;
        addr_lo_n  = addr_lo_q;
        addr_n     = sram_addr_o;
        mis_n      = mis_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_n       = ramOp_i;
                    addr_lo_n  = ramAddr_i[1:0];
                    addr_n     = ramAddr_i[ADDR_W+1:2];
                    mis_n      = mis_req;
                    wait_cnt_n = CW'(WAIT_CYCLES - 1);
                    state_n    = mis_req ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == '0) state_n = DONE;
                else                wait_cnt_n = wait_cnt - 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        in_access = (state_n == ACCESS);
        // Address, byte enables and store drive stay up through DONE for hold.
        active    = ((state_n == ACCESS) || (state_n == DONE)) && !mis_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            op_q        <= MEM_NOP;
            addr_lo_q   <= 2'b00;
            mis_q       <= 1'b0;
            success_o   <= 1'b0;
            misalign_o  <= 1'b0;
            loadData_o  <= '0;
            sram_addr_o <= '0;
            sram_dq_o   <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_be_n   <= 4'b1111;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            op_q        <= op_n;
            addr_lo_q   <= addr_lo_n;
            mis_q       <= mis_n;
            sram_addr_o <= addr_n;
            if (accept) sram_dq_o <= lane_wdata;
            sram_ce_n   <= !in_access;
            sram_oe_n   <= !(in_access && is_load(op_n));
            sram_we_n   <= !(in_access && is_store(op_n));
            sram_dq_oe  <= active && is_store(op_n);
            sram_be_n   <= active ? lane_be_n : 4'b1111;
            success_o   <= (state_n == DONE);
            misalign_o  <= (state_n == DONE) && mis_n;
            // Last ACCESS cycle: sram_dq_i is valid under oe_n; stores give 0.
            if (capture)                loadData_o <= lane_load;
            else if (accept && mis_req) loadData_o <= '0;
        end
    end

    assign state_dbg = state;

endmodule
